// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: walks the round unit through rounds 1..NR, stores
// all round keys, and shares one 4-byte S-box with the cipher datapath.
module aes_key_sched_ctrl #(
  parameter int NR           = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         init_valid,
  output logic         init_ready,
  input  logic [127:0] init_key,
  output logic [127:0] keyw_key,
  output logic [4:0]   keyw_round,
  input  logic [127:0] keyw_round_key,
  input  logic [31:0]  keyw_sbox_req,
  output logic [31:0]  keyw_sbox_resp,
  output logic [31:0]  sbox_in,
  input  logic [31:0]  sbox_out,
  input  logic         dp_sbox_req,
  input  logic [31:0]  dp_sbox_word,
  output logic         dp_sbox_grant,
  output logic [31:0]  dp_sbox_result,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rk_rd_en,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
);

  localparam int            SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [4:0]    NR_R      = 5'(NR);
  localparam logic [SW-1:0] STALL_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      round_q, round_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            keys_valid_q, keys_valid_d;
  logic            busy_q, busy_d;
  logic [127:0]    cur_key_q, cur_key_d;
  logic [127:0]    rd_data_q, rd_data_d;
  logic [127:0]    slot_q [0:NR];
  logic [127:0]    slot_d [0:NR];
  logic            kgrant;

  // Key expansion yields to the datapath until it has been starved STARVE_LIMIT cycles.
  always_comb begin
    kgrant         = (state_q == S_EXPAND) && (!dp_sbox_req || (stall_q == STALL_MAX));
    dp_sbox_grant  = dp_sbox_req && !kgrant;
    sbox_in        = kgrant ? keyw_sbox_req : dp_sbox_word;
    keyw_sbox_resp = sbox_out;
    dp_sbox_result = sbox_out;
  end

  assign init_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign keyw_key   = cur_key_q;
  assign keyw_round = (state_q == S_EXPAND) ? round_q : 5'd0;
  assign busy       = busy_q;
  assign keys_valid = keys_valid_q;
  assign rk_rd_data = rd_data_q;

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    stall_d      = stall_q;
    keys_valid_d = keys_valid_q;
    busy_d       = busy_q;
    cur_key_d    = cur_key_q;
    slot_d       = slot_q;
    rd_data_d    = rd_data_q;

    // Read samples slot_q, so a same-cycle write to that slot is seen only next time.
    if (rk_rd_en) begin
      if (int'(rk_rd_idx) <= NR) rd_data_d = slot_q[rk_rd_idx];
      else                       rd_data_d = '0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (init_valid) begin
          slot_d[0]    = init_key;
          cur_key_d    = init_key;
          round_d      = 5'd1;
          stall_d      = '0;
          keys_valid_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (kgrant) begin
          slot_d[round_q[3:0]] = keyw_round_key;
          cur_key_d            = keyw_round_key;
          stall_d              = '0;
          if (round_q == NR_R) begin
            state_d      = S_DONE;
            keys_valid_d = 1'b1;
            busy_d       = 1'b0;
            round_d      = 5'd0;
          end else begin
            round_d = round_q + 5'd1;
          end
        end else if (stall_q != STALL_MAX) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      round_q      <= 5'd0;
      stall_q      <= '0;
      keys_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      cur_key_q    <= '0;
      rd_data_q    <= '0;
      for (int i = 0; i <= NR; i++) slot_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      stall_q      <= stall_d;
      keys_valid_q <= keys_valid_d;
      busy_q       <= busy_d;
      cur_key_q    <= cur_key_d;
      rd_data_q    <= rd_data_d;
      for (int i = 0; i <= NR; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: models the AES round unit and S-box, scoreboards
// expected current keys and round-key reads.
module tb_aes_key_sched_ctrl;

  localparam int NR = 10;
  localparam int SL = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         init_valid;
  logic         init_ready;
  logic [127:0] init_key;
  logic [127:0] keyw_key;
  logic [4:0]   keyw_round;
  logic [127:0] keyw_round_key;
  logic [31:0]  keyw_sbox_req;
  logic [31:0]  keyw_sbox_resp;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         dp_sbox_req;
  logic [31:0]  dp_sbox_word;
  logic         dp_sbox_grant;
  logic [31:0]  dp_sbox_result;
  logic         busy;
  logic         keys_valid;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_rk [0:10];
  logic [127:0] key_q [$];
  logic [127:0] rd_q  [$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clock = ~clock;

  aes_key_sched_ctrl #(.NR(NR), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .init_valid(init_valid), .init_ready(init_ready), .init_key(init_key),
    .keyw_key(keyw_key), .keyw_round(keyw_round), .keyw_round_key(keyw_round_key),
    .keyw_sbox_req(keyw_sbox_req), .keyw_sbox_resp(keyw_sbox_resp),
    .sbox_in(sbox_in), .sbox_out(sbox_out),
    .dp_sbox_req(dp_sbox_req), .dp_sbox_word(dp_sbox_word),
    .dp_sbox_grant(dp_sbox_grant), .dp_sbox_result(dp_sbox_result),
    .busy(busy), .keys_valid(keys_valid),
    .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(v, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox8(w[31:24]), sbox8(w[23:16]), sbox8(w[15:8]), sbox8(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [4:0] r);
    case (r)
      5'd1: return 8'h01;  5'd2: return 8'h02;  5'd3: return 8'h04;
      5'd4: return 8'h08;  5'd5: return 8'h10;  5'd6: return 8'h20;
      5'd7: return 8'h40;  5'd8: return 8'h80;  5'd9: return 8'h1b;
      5'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Shared S-box and round-unit models; the round unit substitutes through the DUT arbiter.
  assign sbox_out      = subword(sbox_in);
  assign keyw_sbox_req = {keyw_key[23:0], keyw_key[31:24]};
  always_comb begin
    logic [31:0] t, w0, w1, w2, w3;
    t  = keyw_sbox_resp ^ {rcon(keyw_round), 24'h0};
    w0 = keyw_key[127:96] ^ t;
    w1 = keyw_key[95:64] ^ w0;
    w2 = keyw_key[63:32] ^ w1;
    w3 = keyw_key[31:0] ^ w2;
    keyw_round_key = {w0, w1, w2, w3};
  end

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w0, w1, w2, w3, t;
    exp_rk[0] = key;
    {w0, w1, w2, w3} = key;
    for (int r = 1; r <= NR; r++) begin
      t  = subword({w3[23:0], w3[31:24]}) ^ {rcon(5'(r)), 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      exp_rk[r] = {w0, w1, w2, w3};
    end
  endtask

  task automatic run_expand(input logic [127:0] key, input logic dp, input logic hold,
                            input int exp_lat);
    int er, es, n;
    logic kg;
    logic [127:0] ek;
    model_expand(key);
    @(negedge clock);
    init_valid = 1'b1; init_key = key; dp_sbox_req = dp; dp_sbox_word = 32'h1234_5678;
    #1;
    checks++;
    if (init_ready !== 1'b1) begin failures++; $display("FAIL hs_init_ready got=%0b exp=1", init_ready); end
    for (int r = 0; r < NR; r++) key_q.push_back(exp_rk[r]);
    @(posedge clock);
    @(negedge clock);
    if (!hold) init_valid = 1'b0; else init_key = '0;
    checks++;
    if (busy !== 1'b1 || keys_valid !== 1'b0) begin
      failures++; $display("FAIL hs_flags busy=%0b keys_valid=%0b exp busy=1 keys_valid=0", busy, keys_valid);
    end
    er = 1; es = 0; n = 0;
    while (er <= NR && n < 200) begin
      #1;
      kg = !dp || (es == SL);
      checks++;
      if (keyw_round !== 5'(er)) begin failures++; $display("FAIL exp_round cyc=%0d got=%0d exp=%0d", n, keyw_round, er); end
      checks++;
      if (dp_sbox_grant !== (dp && !kg)) begin failures++; $display("FAIL exp_dp_grant cyc=%0d got=%0b exp=%0b", n, dp_sbox_grant, dp && !kg); end
      checks++;
      if (sbox_in !== (kg ? keyw_sbox_req : dp_sbox_word)) begin failures++; $display("FAIL exp_sbox_in cyc=%0d got=%h", n, sbox_in); end
      checks++;
      if (init_ready !== 1'b0) begin failures++; $display("FAIL exp_init_ready cyc=%0d got=%0b exp=0", n, init_ready); end
      if (kg) begin
        ek = key_q.pop_front();
        checks++;
        if (keyw_key !== ek) begin failures++; $display("FAIL exp_cur_key round=%0d got=%h exp=%h", er, keyw_key, ek); end
        er++; es = 0;
      end else if (es < SL) begin
        es++;
      end
      n++;
      @(negedge clock);
    end
    init_valid = 1'b0; dp_sbox_req = 1'b0;
    #1;
    checks++;
    if (n !== exp_lat) begin failures++; $display("FAIL exp_latency got=%0d exp=%0d", n, exp_lat); end
    checks++;
    if (keys_valid !== 1'b1 || busy !== 1'b0 || init_ready !== 1'b1 || keyw_round !== 5'd0) begin
      failures++;
      $display("FAIL done_flags keys_valid=%0b busy=%0b init_ready=%0b round=%0d exp 1 0 1 0",
               keys_valid, busy, init_ready, keyw_round);
    end
  endtask

  task automatic test_readback(input logic [127:0] exp1, input logic [127:0] exp10);
    int order [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 11, 10};
    logic [127:0] e, got;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clock);
      if (i > 0) begin
        got = rd_q.pop_front();
        checks++;
        if (rk_rd_data !== got) begin failures++; $display("FAIL rd_idx%0d got=%h exp=%h", order[i-1], rk_rd_data, got); end
      end
      if (i < 12) begin
        rk_rd_en = 1'b1; rk_rd_idx = 4'(order[i]);
        if (order[i] == 11)      e = '0;
        else if (order[i] == 1)  e = exp1;
        else if (order[i] == 10) e = exp10;
        else                     e = exp_rk[order[i]];
        rd_q.push_back(e);
      end else begin
        rk_rd_en = 1'b0; rk_rd_idx = 4'd3;
      end
    end
    @(negedge clock);
    checks++;
    if (rk_rd_data !== exp10) begin failures++; $display("FAIL rd_hold got=%h exp=%h", rk_rd_data, exp10); end
  endtask

  task automatic test_reset();
    reset = 1'b1; init_valid = 1'b0; init_key = '0; dp_sbox_req = 1'b0; dp_sbox_word = '0;
    rk_rd_en = 1'b0; rk_rd_idx = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (init_ready !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b0 || keyw_round !== 5'd0 ||
        rk_rd_data !== 128'h0 || keyw_key !== 128'h0 || dp_sbox_grant !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ready=%0b busy=%0b kv=%0b round=%0d rd=%h key=%h",
               init_ready, busy, keys_valid, keyw_round, rk_rd_data, keyw_key);
    end
    reset = 1'b0;
  endtask

  task automatic test_expand_nominal();
    run_expand(FIPS_KEY, 1'b0, 1'b0, NR);
    test_readback(FIPS_RK1, FIPS_RK10);
  endtask

  task automatic test_contention_hold_init();
    run_expand(FIPS_KEY, 1'b1, 1'b1, NR * (SL + 1));
    test_readback(FIPS_RK1, FIPS_RK10);
  endtask

  task automatic test_rekey_zero();
    run_expand(128'h0, 1'b0, 1'b0, NR);
    test_readback(exp_rk[1], ZERO_RK10);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    init_valid = 1'b1; init_key = FIPS_KEY;
    @(negedge clock);
    init_valid = 1'b0; rk_rd_en = 1'b1; rk_rd_idx = 4'd0;
    @(negedge clock);
    rk_rd_en = 1'b0;
    checks++;
    if (rk_rd_data !== FIPS_KEY) begin failures++; $display("FAIL rd_during_expand got=%h exp=%h", rk_rd_data, FIPS_KEY); end
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || keys_valid !== 1'b0 || init_ready !== 1'b1 || keyw_round !== 5'd0 ||
        rk_rd_data !== 128'h0 || keyw_key !== 128'h0) begin
      failures++;
      $display("FAIL mid_reset busy=%0b kv=%0b ready=%0b round=%0d rd=%h key=%h",
               busy, keys_valid, init_ready, keyw_round, rk_rd_data, keyw_key);
    end
    @(negedge clock);
    reset = 1'b0;
    rk_rd_en = 1'b1; rk_rd_idx = 4'd10;
    @(negedge clock);
    rk_rd_en = 1'b0;
    checks++;
    if (rk_rd_data !== 128'h0) begin failures++; $display("FAIL slot_cleared got=%h exp=0", rk_rd_data); end
    run_expand(FIPS_KEY, 1'b0, 1'b0, NR);
    test_readback(FIPS_RK1, FIPS_RK10);
  endtask

  task automatic test_dp_idle();
    @(negedge clock);
    dp_sbox_req = 1'b1; dp_sbox_word = 32'h0000_0000;
    #1;
    checks++;
    if (dp_sbox_grant !== 1'b1 || sbox_in !== 32'h0 || dp_sbox_result !== 32'h6363_6363) begin
      failures++; $display("FAIL dp_idle_zero grant=%0b in=%h res=%h exp 1 00000000 63636363",
                           dp_sbox_grant, sbox_in, dp_sbox_result);
    end
    dp_sbox_word = 32'h5353_5353;
    #1;
    checks++;
    if (dp_sbox_grant !== 1'b1 || sbox_in !== 32'h5353_5353 || dp_sbox_result !== 32'hedede_ded) begin
      failures++; $display("FAIL dp_idle_53 grant=%0b in=%h res=%h exp 1 53535353 edededed",
                           dp_sbox_grant, sbox_in, dp_sbox_result);
    end
    dp_sbox_req = 1'b0;
    #1;
    checks++;
    if (dp_sbox_grant !== 1'b0) begin failures++; $display("FAIL dp_idle_noreq grant=%0b exp=0", dp_sbox_grant); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_dp_idle();
    test_expand_nominal();
    test_contention_hold_init();
    test_rekey_zero();
    test_reset_mid();
    test_dp_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequencer for the single-round AES-128 key-expansion unit.
- Loads a cipher key, then steps the round unit through rounds 1..10, one round per granted cycle, and stores all 11 round keys in an internal register file.
- Arbitrates the shared 4-byte S-box between the key-expansion round unit and the cipher datapath.
- Sits between the key-load interface and the encrypt/decrypt round datapath.

Parameters:
- NR, 10, last round index; fixed at 10 for AES-128 (round keys 0..NR stored).
- STARVE_LIMIT, 4, consecutive stalled EXPAND cycles after which key expansion takes the S-box for one cycle.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- init_valid  input  1  new cipher key offered
- init_ready  output  1  controller accepts a key (IDLE or DONE)
- init_key  input  128  cipher key, word0 in [127:96]
- keyw_key  output  128  previous round key presented to the round unit
- keyw_round  output  5  round index presented to the round unit (1..NR; 0 outside EXPAND)
- keyw_round_key  input  128  combinational next round key from the round unit
- keyw_sbox_req  input  32  word the round unit wants substituted
- keyw_sbox_resp  output  32  substituted word returned to the round unit
- sbox_in  output  32  word driven to the shared S-box
- sbox_out  input  32  combinational S-box result
- dp_sbox_req  input  1  datapath requests the S-box this cycle
- dp_sbox_word  input  32  datapath word to substitute
- dp_sbox_grant  output  1  datapath owns the S-box this cycle
- dp_sbox_result  output  32  S-box result for the datapath (valid when granted)
- busy  output  1  expansion in progress
- keys_valid  output  1  all round keys 0..NR are stored and current
- rk_rd_en  input  1  round-key read strobe
- rk_rd_idx  input  4  round-key index
- rk_rd_data  output  128  registered round-key read data

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, round counter=0, stall counter=0, keys_valid=0, busy=0, rk_rd_data=0.
  - All key slots and the current-key register are cleared to 0.
  - Reset asserted mid-EXPAND aborts immediately; no partial keys_valid.
- States:
  - IDLE -> EXPAND on init_valid && init_ready.
  - EXPAND -> DONE when round NR is written.
  - DONE -> EXPAND on a new init handshake.
- init_ready=1 in IDLE and DONE, 0 in EXPAND; init_valid during EXPAND is ignored.
- On handshake:
  - slot[0]=init_key, cur_key=init_key, round=1.
  - keys_valid cleared in the same edge; busy=1 from the next cycle.
- EXPAND outputs: keyw_key=cur_key, keyw_round=round.
- S-box arbitration (combinational, same cycle):
  - Key-expansion grant kgrant = (state==EXPAND) && (!dp_sbox_req || stall==STARVE_LIMIT).
  - dp_sbox_grant = dp_sbox_req && !kgrant.
  - sbox_in = kgrant ? keyw_sbox_req : dp_sbox_word; sbox_in = dp_sbox_word when neither is granted.
  - keyw_sbox_resp = sbox_out; dp_sbox_result = sbox_out.
  - Outside EXPAND the datapath is always granted when it requests.
- EXPAND cycle with kgrant:
  - slot[round]=keyw_round_key, cur_key=keyw_round_key, round+=1, stall=0.
  - If round==NR: next state DONE, keys_valid=1, busy=0, round=0.
- EXPAND cycle without kgrant: stall+=1, saturating at STARVE_LIMIT; no state change.
- Latency: 10 cycles from handshake to keys_valid with no datapath contention. Worst case with continuous dp_sbox_req is 10*(STARVE_LIMIT+1) cycles.
- Read port:
  - On rk_rd_en, rk_rd_data <= slot[rk_rd_idx] at the next edge; rk_rd_data holds when rk_rd_en=0.
  - idx>NR returns 0.
  - Reads during EXPAND return the slot's current content; old-key slots not yet rewritten keep stale values, and keys_valid=0 flags this.
- Simultaneous write and read of the same slot returns the old value (read-before-write).

Test Plan:
- Reset, then init key 2b7e151628aed2a6abf7158809cf4f3c with dp_sbox_req=0 -> keys_valid rises exactly 10 cycles after handshake. slot1=a0fafe1788542cb123a339392a6c7605, slot10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Read idx 0, 10, 11 after completion -> one cycle later 2b7e...4f3c, d014...0ca6, 0.
- Hold dp_sbox_req=1 throughout expansion, STARVE_LIMIT=4 -> key unit granted once every 5 EXPAND cycles, keys_valid after 50 cycles. dp_sbox_grant=0 exactly on those grant cycles. Final keys identical to the first test.
- init_valid held high during EXPAND -> init_ready=0, ignored. A second key (all-zero) offered in DONE -> keys_valid drops next cycle; slot10 becomes b4ef5bcb3e92e21123e951cf6f8f188e after 10 cycles.
- Assert reset at cycle 5 of EXPAND -> all outputs return to reset values asynchronously. A subsequent init completes normally.
- Datapath S-box request with word 00000000 while in IDLE -> dp_sbox_grant=1, sbox_in=00000000, dp_sbox_result equals sbox_out (63636363 with the real S-box).
